bus_dma_arbiter: RTL and testbench

- Per-cycle arbiter for the shared 64K memory bus between the 6502 CPU, ANTIC DMA requests and DRAM refresh.
- Decides who drives `address`/`re_L`/`we_L` each phi2 cycle.
- Drives `halt_L` to stall the CPU, returns ANTIC fetch data, and schedules refresh slots internally.
- Sits between ANTIC, the CPU and the `memory256x256` RAM.

---
 rtl/bus_pkg.sv | 15 +
 rtl/refresh_scheduler.sv | 46 ++++
 rtl/bus_dma_arbiter.sv | 107 ++++++++++
 tb/tb_bus_dma_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus arbiter: bus widths, refresh base
// address and the arbiter state encoding.
package bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] REF_ADDR_BASE = 16'h0000;

    typedef enum logic [2:0] {
        S_CPU  = 3'd0,
        S_HALT = 3'd1,
        S_DMA  = 3'd2,
        S_REF  = 3'd3,
        S_HOLD = 3'd4
    } bus_state_t;
endpackage

// File: rtl/refresh_scheduler.sv
// DRAM refresh bookkeeping: free-running interval timer, saturating backlog
// of owed refresh slots, refresh row counter and a sticky lost-request flag.
module refresh_scheduler #(
    parameter int REFRESH_INTERVAL = 12,
    parameter int MAX_REF_PENDING  = 3,
    parameter int REF_ROW_W        = 8
) (
    input  logic                 phi2,
    input  logic                 RST_L,
    input  logic                 ref_served,
    output logic                 ref_pending_nz,
    output logic [REF_ROW_W-1:0] ref_row,
    output logic                 ref_overflow
);
    localparam int TIMER_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int PEND_W  = $clog2(MAX_REF_PENDING + 1);

    logic [TIMER_W-1:0] timer;
    logic [PEND_W-1:0]  pending;
    logic               wrap;

    assign wrap           = (timer == TIMER_W'(REFRESH_INTERVAL - 1));
    assign ref_pending_nz = (pending != '0);

    always_ff @(posedge phi2 or negedge RST_L) begin
        if (!RST_L) begin
            timer        <= '0;
            pending      <= '0;
            ref_row      <= '0;
            ref_overflow <= 1'b0;
        end else begin
            timer <= wrap ? '0 : timer + 1'b1;
            if (ref_served)
                ref_row <= ref_row + 1'b1;
            // A new request and a serviced slot on the same edge cancel out.
            if (wrap && !ref_served) begin
                if (pending == PEND_W'(MAX_REF_PENDING))
                    ref_overflow <= 1'b1;
                else
                    pending <= pending + 1'b1;
            end else if (!wrap && ref_served && pending != '0) begin
                pending <= pending - 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_dma_arbiter.sv
// Per-cycle owner selection for the shared memory bus: ANTIC DMA, then DRAM
// refresh, then the 6502, with CPU halting and DMA read-data return.
module bus_dma_arbiter
    import bus_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 12,
    parameter int MAX_REF_PENDING  = 3,
    parameter int REF_ROW_W        = 8
) (
    input  logic              phi2,
    input  logic              RST_L,
    input  logic              antic_req,
    input  logic [ADDR_W-1:0] antic_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] DB,
    output logic [ADDR_W-1:0] address,
    output logic              re_L,
    output logic              we_L,
    output logic              halt_L,
    output logic              REF_L,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_data,
    output logic              ref_overflow
);
    bus_state_t           state, state_nx;
    logic                 ref_pending_nz;
    logic [REF_ROW_W-1:0] ref_row;
    logic                 ref_served;

    assign ref_served = (state == S_REF);

    refresh_scheduler #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_REF_PENDING  (MAX_REF_PENDING),
        .REF_ROW_W        (REF_ROW_W)
    ) u_refresh (
        .phi2           (phi2),
        .RST_L          (RST_L),
        .ref_served     (ref_served),
        .ref_pending_nz (ref_pending_nz),
        .ref_row        (ref_row),
        .ref_overflow   (ref_overflow)
    );

    always_ff @(posedge phi2 or negedge RST_L) begin
        if (!RST_L) begin
            state    <= S_CPU;
            dma_ack  <= 1'b0;
            dma_data <= '0;
        end else begin
            state   <= state_nx;
            dma_ack <= (state == S_DMA);
            if (state == S_DMA)
                dma_data <= DB;
        end
    end

    always_comb begin
        state_nx = state;
        address  = cpu_addr;
        re_L     = ~cpu_rw;
        we_L     = cpu_rw;
        halt_L   = 1'b1;
        REF_L    = 1'b1;
        unique case (state)
            S_CPU: begin
                if (antic_req || ref_pending_nz)
                    state_nx = S_HALT;
            end
            // CPU keeps the bus here so a write in flight can finish.
            S_HALT: begin
                halt_L = 1'b0;
                if (cpu_rw) begin
                    if (antic_req)           state_nx = S_DMA;
                    else if (ref_pending_nz) state_nx = S_REF;
                    else                     state_nx = S_CPU;
                end
            end
            S_DMA: begin
                address  = antic_addr;
                re_L     = 1'b0;
                we_L     = 1'b1;
                halt_L   = 1'b0;
                state_nx = S_HOLD;
            end
            S_REF: begin
                address  = REF_ADDR_BASE | ADDR_W'(ref_row);
                re_L     = 1'b1;
                we_L     = 1'b1;
                REF_L    = 1'b0;
                halt_L   = 1'b0;
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                address = antic_addr;
                re_L    = 1'b1;
                we_L    = 1'b1;
                halt_L  = 1'b0;
                if (antic_req)           state_nx = S_DMA;
                else if (ref_pending_nz) state_nx = S_REF;
                else                     state_nx = S_CPU;
            end
            default: state_nx = S_CPU;
        endcase
    end
endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Bench for bus_dma_arbiter: directed stimulus, a cycle-level behavioural
// model compared on every negedge, plus hand-computed spot checks.
module tb_bus_dma_arbiter;
    logic        phi2 = 1'b0;
    logic        RST_L = 1'b1;
    logic        antic_req = 1'b0;
    logic [15:0] antic_addr = 16'h0000;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rw = 1'b1;
    logic [7:0]  DB;
    logic [15:0] address;
    logic        re_L, we_L, halt_L, REF_L, dma_ack, ref_overflow;
    logic [7:0]  dma_data;

    bus_dma_arbiter dut (
        .phi2(phi2), .RST_L(RST_L), .antic_req(antic_req), .antic_addr(antic_addr),
        .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .DB(DB), .address(address),
        .re_L(re_L), .we_L(we_L), .halt_L(halt_L), .REF_L(REF_L),
        .dma_ack(dma_ack), .dma_data(dma_data), .ref_overflow(ref_overflow)
    );

    always #5 phi2 = ~phi2;

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        if (a == 16'h0400) return 8'h70;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    assign DB = mem_val(address);

    int n_cmp = 0;
    int n_bad = 0;
    int cnt;

    always @(posedge phi2 or negedge RST_L)
        if (!RST_L) cnt <= 0;
        else        cnt <= cnt + 1;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cnt, act, exp);
        end
    endtask

    // Model: who owns the bus this cycle, and refresh debt as plain counters.
    localparam int P_RUN = 0, P_STALL = 1, P_FETCH = 2, P_REFRESH = 3, P_GAP = 4;
    int          m_ph, m_tick, m_backlog, m_row;
    bit          m_lost, m_ack;
    logic [7:0]  m_data;
    int          n_ph, n_tick, n_backlog, n_row, want;
    bit          n_lost, n_ack, n_ok = 0;
    logic [7:0]  n_data;
    logic [15:0] e_addr;
    logic        e_re, e_we, e_halt, e_ref, wrap, served;

    always @(negedge phi2) begin
        if (!RST_L) begin
            m_ph = P_RUN; m_tick = 0; m_backlog = 0; m_row = 0;
            m_lost = 0; m_ack = 0; m_data = 8'h00;
        end
        e_addr = cpu_addr; e_re = ~cpu_rw; e_we = cpu_rw; e_halt = (m_ph == P_RUN); e_ref = 1;
        if (m_ph == P_FETCH)   begin e_addr = antic_addr; e_re = 0; e_we = 1; end
        if (m_ph == P_GAP)     begin e_addr = antic_addr; e_re = 1; e_we = 1; end
        if (m_ph == P_REFRESH) begin e_addr = 16'(m_row); e_re = 1; e_we = 1; e_ref = 0; end
        cmp("address", address, e_addr);
        cmp("re_L", re_L, e_re);
        cmp("we_L", we_L, e_we);
        cmp("halt_L", halt_L, e_halt);
        cmp("REF_L", REF_L, e_ref);
        cmp("dma_ack", dma_ack, m_ack);
        cmp("dma_data", dma_data, m_data);
        cmp("ref_overflow", ref_overflow, m_lost);

        n_ok = RST_L;
        want = antic_req ? P_FETCH : (m_backlog > 0 ? P_REFRESH : P_RUN);
        case (m_ph)
            P_RUN:   n_ph = (antic_req || m_backlog > 0) ? P_STALL : P_RUN;
            P_STALL: n_ph = cpu_rw ? want : P_STALL;
            P_GAP:   n_ph = want;
            default: n_ph = P_GAP;
        endcase
        wrap      = (m_tick == 11);
        served    = (m_ph == P_REFRESH);
        n_tick    = (m_tick + 1) % 12;
        n_lost    = m_lost | (wrap && !served && m_backlog == 3);
        n_backlog = m_backlog + int'(wrap) - int'(served);
        if (n_backlog > 3) n_backlog = 3;
        n_row     = (m_row + int'(served)) % 256;
        n_ack     = (m_ph == P_FETCH);
        n_data    = (m_ph == P_FETCH) ? mem_val(antic_addr) : m_data;
    end

    always @(posedge phi2)
        if (n_ok && RST_L) begin
            m_ph = n_ph; m_tick = n_tick; m_backlog = n_backlog; m_row = n_row;
            m_lost = n_lost; m_ack = n_ack; m_data = n_data;
        end

    task automatic goto(input int n);
        while (cnt < n) begin
            @(posedge phi2);
            #1;
        end
    endtask

    task automatic summary;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #50000;
        n_bad++;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cnt);
        summary();
        $finish;
    end

    initial begin
        #1 RST_L = 1'b0; cpu_addr = 16'h1234; cpu_rw = 1'b1;
        repeat (3) @(posedge phi2);
        #1 RST_L = 1'b1;
        // first refresh request: timer wraps after 12 edges
        #2 cmp("t1_c0_halt", halt_L, 1'b1); cmp("t1_c0_addr", address, 16'h1234);
        goto(12); #2 cmp("t1_c12_halt", halt_L, 1'b1);
        goto(13); #2 cmp("t1_c13_halt", halt_L, 1'b0);
        goto(14); #2 cmp("t1_ref0_strobe", REF_L, 1'b0); cmp("t1_ref0_addr", address, 16'h0000);
        goto(26); #2 cmp("t1_ref1_strobe", REF_L, 1'b0); cmp("t1_ref1_addr", address, 16'h0001);
        // single DMA read
        goto(28); antic_req = 1'b1; antic_addr = 16'h0400;
        goto(30); #2 cmp("t2_dma_addr", address, 16'h0400); cmp("t2_dma_re", re_L, 1'b0);
        goto(31); antic_req = 1'b0;
        #2 cmp("t2_ack", dma_ack, 1'b1); cmp("t2_data", dma_data, 8'h70);
        goto(32); #2 cmp("t2_cpu_back", halt_L, 1'b1); cmp("t2_ack_off", dma_ack, 1'b0);
        // request during CPU writes
        cpu_rw = 1'b0; antic_req = 1'b1; antic_addr = 16'h0500;
        goto(34); #2 cmp("t3_halt", halt_L, 1'b0); cmp("t3_we", we_L, 1'b0); cmp("t3_addr", address, 16'h1234);
        goto(35); cpu_rw = 1'b1;
        goto(36); #2 cmp("t3_dma_re", re_L, 1'b0); cmp("t3_dma_addr", address, 16'h0500);
        goto(37); #2 cmp("t3_ack", dma_ack, 1'b1); cmp("t3_data", dma_data, 8'h5F);
        // DMA beats the pending refresh in S_HOLD
        goto(38); #2 cmp("t5_dma_wins", re_L, 1'b0); cmp("t5_no_ref", REF_L, 1'b1);
        goto(39); antic_req = 1'b0;
        goto(40); #2 cmp("t5_ref_strobe", REF_L, 1'b0); cmp("t5_ref_addr", address, 16'h0002);
        goto(42); #2 cmp("t5_cpu_back", halt_L, 1'b1);
        // long DMA burst starves refresh into overflow
        antic_req = 1'b1;
        for (int c = 42; c < 86; c++) begin
            goto(c);
            antic_addr = 16'h1000 + 16'(c);
            if (c == 45) begin #2 cmp("t4_ack45", dma_ack, 1'b1); end
            if (c == 46) begin #2 cmp("t4_ack46", dma_ack, 1'b0); cmp("t4_dma46", re_L, 1'b0); end
            if (c == 83) begin #2 cmp("t4_ovf_before", ref_overflow, 1'b0); end
            if (c == 84) begin #2 cmp("t4_ovf_after", ref_overflow, 1'b1); end
        end
        goto(86); antic_req = 1'b0;
        goto(88); #2 cmp("t4_ref_a", REF_L, 1'b0); cmp("t4_ref_a_addr", address, 16'h0003);
        goto(90); #2 cmp("t4_ref_b", REF_L, 1'b0); cmp("t4_ref_b_addr", address, 16'h0004);
        goto(92); #2 cmp("t4_ref_c", REF_L, 1'b0); cmp("t4_ref_c_addr", address, 16'h0005);
        goto(94); #2 cmp("t4_cpu_back", halt_L, 1'b1); cmp("t4_ovf_sticky", ref_overflow, 1'b1);
        // reset in the middle of a DMA slot
        antic_req = 1'b1; antic_addr = 16'h0600;
        goto(96); #2 cmp("t6_in_dma", re_L, 1'b0);
        RST_L = 1'b0;
        #1 cmp("t6_halt", halt_L, 1'b1); cmp("t6_ref", REF_L, 1'b1); cmp("t6_ack", dma_ack, 1'b0);
        cmp("t6_data", dma_data, 8'h00); cmp("t6_ovf", ref_overflow, 1'b0); cmp("t6_addr", address, 16'h1234);
        repeat (2) @(posedge phi2);
        #1 cmp("t6_ack_held", dma_ack, 1'b0);
        antic_req = 1'b0; RST_L = 1'b1;
        goto(12); #2 cmp("t6_no_backlog", halt_L, 1'b1);
        goto(13); #2 cmp("t6_first_halt", halt_L, 1'b0);
        goto(14); #2 cmp("t6_row_reset", address, 16'h0000); cmp("t6_ref_strobe", REF_L, 1'b0);
        goto(16);
        summary();
        $finish;
    end
endmodule
